mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- EX/MEM pipeline register plus load/store controller that sits directly upstream of the data memory.
- Latches memory requests from the execute stage and checks alignment.
- Replicates store data onto the byte lanes the memory writes, because the memory writes wdata lane-for-lane.
- Drives the memory address, data, write-enable and op lines, and registers the load or ALU result into the MEM/WB register for write-back.

Parameters:
- ADDR_W, 32, address width; only [7:0] is meaningful to the 256-byte memory.
- DATA_W, 32, data path width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold the MEM stage register
- flush  in  1  kill the instruction in the MEM stage
- ex_valid  in  1  EX stage holds a valid instruction
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_mem_op  in  3  000 LW/SW, 001 SH, 010 SB, 100 LH, 101 LHU, 110 LB, 111 LBU
- ex_alu_result  in  32  effective address, or ALU result for non-memory instructions
- ex_store_data  in  32  unshifted rs2 value
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- dm_addr  out  32  to memory addr
- dm_wdata  out  32  lane-replicated store data
- dm_we  out  1  memory write enable
- dm_mem_op  out  3  to memory mem_op
- dm_rdata  in  32  extended load data from memory
- wb_valid  out  1  MEM/WB register valid
- wb_rd  out  5  write-back register
- wb_reg_write  out  1  write-back enable
- wb_data  out  32  load data or ALU result
- exc_misalign  out  1  sticky misaligned-access fault
- exc_addr  out  32  faulting address
- exc_ack  in  1  clears the fault

Behaviour:
- Reset (async, immediate): all MEM and WB register fields go to 0, state=RUN, exc_misalign=0, exc_addr=0, dm_we=0. Consequently dm_addr=0, dm_wdata=0 and dm_mem_op=000.
- EX/MEM capture on each rising edge, in priority order:
  - flush: m_valid<=0.
  - else stall: hold all fields.
  - else capture all ex_* fields, with m_valid<=ex_valid.
- Misalignment check, combinational on the MEM register:
  - mis = m_valid & (m_read|m_write) & condition.
  - Word ops (000): condition is addr[1:0]!=0.
  - Half ops (001,100,101): condition is addr[0]=1.
  - Byte ops: never misaligned.
- Memory drive, combinational:
  - dm_addr=m_addr and dm_mem_op=m_op.
  - dm_we = m_valid & m_write & ~mis & state==RUN & ~flush.
  - The write commits on the same edge that advances MEM to WB. While stalled, the same store is re-driven each cycle; this is idempotent.
- Store lane replication for dm_wdata:
  - SW: data unchanged.
  - SH: {d[15:0],d[15:0]}.
  - SB: {4{d[7:0]}}.
  - Any non-store: 0.
- MEM/WB capture on each rising edge, in priority order:
  - stall or flush: wb_valid<=0 and wb_reg_write<=0 (bubble).
  - else:
    - wb_valid<=m_valid.
    - wb_rd<=m_rd.
    - wb_reg_write <= m_valid & m_reg_write & ~mis & state==RUN.
    - wb_data <= m_read ? dm_rdata : m_alu_result.
- Latency: EX input at edge N → memory access during cycle N → wb_* valid after edge N+1.
- State machine RUN/FAULT:
  - RUN→FAULT on an edge where mis=1 and neither stall nor flush is asserted. That edge sets exc_misalign<=1 and exc_addr<=m_addr.
  - In FAULT: dm_we is forced 0 and wb_reg_write is forced 0. The pipeline keeps moving, so the trap logic must flush it.
  - FAULT→RUN on exc_ack. exc_misalign clears on the same edge.
  - If exc_ack and a new mis arrive on the same edge, the new fault wins: stay in FAULT and latch the new addr.
- Simultaneous stall+flush: flush wins for the MEM register, and WB gets a bubble.

Decomposition:
- Shared package:
  - MEM_OP_* localparams: WORD=000, SH=001, SB=010, LH=100, LHU=101, LB=110, LBU=111.
  - State encoding ST_RUN/ST_FAULT.
  - The data_mem stage already uses these mem_op codes, so it should import the same constants.
- Sub-module store_align: pure combinational lane replication plus the misalignment check, reusable by a future store buffer.

Test Plan:
- SB: op=010, addr=0x11, data=0xABCD12EF → dm_wdata=0xEFEFEFEF, dm_we=1 for one cycle; a following LBU at 0x11 gives wb_data=0x000000EF two edges after issue.
- SH: op=001, addr=0x22, data=0x0000BEEF → dm_wdata=0xBEEFBEEF; a following LH at 0x22 gives wb_data=0xFFFFBEEF.
- Misaligned LW at addr 0x06 → dm_we=0, wb_reg_write=0, exc_misalign=1, exc_addr=0x06 held until exc_ack; cleared the cycle after exc_ack.
- SW to 0x40 with stall held 3 cycles → MEM fields stable, wb_valid=0 during the stall, memory word 0x40 written with the correct data, and exactly one WB entry issued.
- flush and stall together while a store is in MEM → dm_we=0 that cycle, no WB entry, and memory is unchanged.
- rst asserted mid-store, asynchronously and between edges → dm_we drops immediately, all wb_* are 0, and state=RUN.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared memory-op encodings and LSU state type for the MEM stage and data memory.
package mem_stage_lsu_pkg;

    localparam logic [2:0] MEM_OP_WORD = 3'b000;
    localparam logic [2:0] MEM_OP_SH   = 3'b001;
    localparam logic [2:0] MEM_OP_SB   = 3'b010;
    localparam logic [2:0] MEM_OP_LH   = 3'b100;
    localparam logic [2:0] MEM_OP_LHU  = 3'b101;
    localparam logic [2:0] MEM_OP_LB   = 3'b110;
    localparam logic [2:0] MEM_OP_LBU  = 3'b111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_store_align.sv
// Store byte-lane replication and access alignment check; purely combinational.
module store_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic              access,
    input  logic              store,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] wdata,
    output logic              mis
);

    always_comb begin
        wdata = '0;
        if (store) begin
            unique case (op)
                MEM_OP_WORD: wdata = store_data;
                MEM_OP_SH:   wdata = {(DATA_W/16){store_data[15:0]}};
                MEM_OP_SB:   wdata = {(DATA_W/8){store_data[7:0]}};
                default:     wdata = '0;
            endcase
        end
    end

    always_comb begin
        mis = 1'b0;
        unique case (op)
            MEM_OP_WORD:                     mis = access & (addr_lo != 2'b00);
            MEM_OP_SH, MEM_OP_LH, MEM_OP_LHU: mis = access & addr_lo[0];
            default:                         mis = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// EX/MEM register, load/store controller and MEM/WB register in front of the data memory.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    output logic [2:0]        dm_mem_op,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc_misalign,
    output logic [ADDR_W-1:0] exc_addr,
    input  logic              exc_ack
);

    logic              m_valid;
    logic              m_read;
    logic              m_write;
    logic [2:0]        m_op;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_store_data;
    logic [4:0]        m_rd;
    logic              m_reg_write;

    lsu_state_t state, state_next;
    logic       mis;
    logic       mis_take;
    logic       fault_set;
    logic       fault_clr;
    logic       run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid      <= 1'b0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_op         <= '0;
            m_addr       <= '0;
            m_store_data <= '0;
            m_rd         <= '0;
            m_reg_write  <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (!stall) begin
            m_valid      <= ex_valid;
            m_read       <= ex_mem_read;
            m_write      <= ex_mem_write;
            m_op         <= ex_mem_op;
            m_addr       <= ex_alu_result;
            m_store_data <= ex_store_data;
            m_rd         <= ex_rd;
            m_reg_write  <= ex_reg_write;
        end
    end

    store_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .op         (m_op),
        .addr_lo    (m_addr[1:0]),
        .access     (m_valid & (m_read | m_write)),
        .store      (m_write),
        .store_data (m_store_data),
        .wdata      (dm_wdata),
        .mis        (mis)
    );

    assign run       = (state == ST_RUN);
    assign dm_addr   = m_addr;
    assign dm_mem_op = m_op;
    assign dm_we     = m_valid & m_write & ~mis & run & ~flush;
    assign mis_take  = mis & ~stall & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // A fault arriving together with exc_ack re-arms rather than clears.
    always_comb begin
        state_next = state;
        fault_set  = 1'b0;
        fault_clr  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (mis_take) begin
                    state_next = ST_FAULT;
                    fault_set  = 1'b1;
                end
            end
            ST_FAULT: begin
                if (exc_ack) begin
                    if (mis_take) begin
                        fault_set = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                        fault_clr  = 1'b1;
                    end
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_misalign <= 1'b0;
            exc_addr     <= '0;
        end else if (fault_set) begin
            exc_misalign <= 1'b1;
            exc_addr     <= m_addr;
        end else if (fault_clr) begin
            exc_misalign <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
        end else if (stall || flush) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_valid     <= m_valid;
            wb_rd        <= m_rd;
            wb_reg_write <= m_valid & m_reg_write & ~mis & run;
            wb_data      <= m_read ? dm_rdata : DATA_W'(m_addr);
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: vector table, WB scoreboard, and a 256-byte data memory model.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_mem_op;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [2:0]  dm_mem_op;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        exc_misalign;
    logic [31:0] exc_addr;
    logic        exc_ack;

    mem_stage_lsu #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_op     (ex_mem_op),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_we         (dm_we),
        .dm_mem_op     (dm_mem_op),
        .dm_rdata      (dm_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .exc_misalign  (exc_misalign),
        .exc_addr      (exc_addr),
        .exc_ack       (exc_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: lane-for-lane writes, extended loads.
    logic [7:0]  mem [256];
    logic        mem_init;
    logic [31:0] mword;

    function automatic logic [31:0] ext(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (op)
            3'b100:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0000, h};
            3'b110:  return {{24{b[7]}}, b};
            3'b111:  return {24'h000000, b};
            default: return w;
        endcase
    endfunction

    assign mword    = {mem[{dm_addr[7:2], 2'd3}], mem[{dm_addr[7:2], 2'd2}],
                       mem[{dm_addr[7:2], 2'd1}], mem[{dm_addr[7:2], 2'd0}]};
    assign dm_rdata = ext(dm_mem_op, dm_addr[1:0], mword);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (dm_we) begin
            case (dm_mem_op)
                3'b000: begin
                    mem[{dm_addr[7:2], 2'd0}] <= dm_wdata[7:0];
                    mem[{dm_addr[7:2], 2'd1}] <= dm_wdata[15:8];
                    mem[{dm_addr[7:2], 2'd2}] <= dm_wdata[23:16];
                    mem[{dm_addr[7:2], 2'd3}] <= dm_wdata[31:24];
                end
                3'b001: begin
                    mem[{dm_addr[7:2], dm_addr[1], 1'b0}] <= dm_wdata[{dm_addr[1], 4'b0000} +: 8];
                    mem[{dm_addr[7:2], dm_addr[1], 1'b1}] <= dm_wdata[{dm_addr[1], 4'b1000} +: 8];
                end
                3'b010: mem[dm_addr[7:0]] <= dm_wdata[{dm_addr[1:0], 3'b000} +: 8];
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        v;
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [31:0] exp_wb;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        chk;
    } sb_t;

    sb_t q[$];
    int  n_vec;
    int  n_mis;

    function automatic vec_t mk(input logic v, input logic r, input logic w, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                                input logic rw, input logic [31:0] ewd, input logic ewe, input logic [31:0] ewb);
        vec_t t;
        t.v = v; t.rd_en = r; t.wr_en = w; t.op = op; t.addr = a; t.sdata = sd;
        t.rd = rd; t.rw = rw; t.exp_wdata = ewd; t.exp_we = ewe; t.exp_wb = ewb;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic rw, input logic [31:0] data, input logic c);
        sb_t e;
        e.rd = rd; e.rw = rw; e.data = data; e.chk = c;
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd, input logic rw);
        ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_mem_op = op;
        ex_alu_result = a; ex_store_data = sd; ex_rd = rd; ex_reg_write = rw;
    endtask

    // Advance one edge and retire any WB entry against the scoreboard.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        if (wb_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d, required no entry (t=%0t)", wb_rd, $time);
            end else begin
                e = q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                if (e.chk) chk("wb_data", wb_data, e.data);
            end
        end
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
            tick();
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[{a[7:2], 2'd3}], mem[{a[7:2], 2'd2}], mem[{a[7:2], 2'd1}], mem[{a[7:2], 2'd0}]};
    endfunction

    vec_t vt[14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish before 100us");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_mis = 0;
        vt[0]  = mk(1, 0, 1, 3'b010, 32'h11, 32'hABCD12EF, 0, 0, 32'hEFEFEFEF, 1, 32'h11);
        vt[1]  = mk(1, 1, 0, 3'b111, 32'h11, 32'h0,        3, 1, 32'h0,        0, 32'h000000EF);
        vt[2]  = mk(1, 0, 1, 3'b001, 32'h22, 32'h0000BEEF, 0, 0, 32'hBEEFBEEF, 1, 32'h22);
        vt[3]  = mk(1, 1, 0, 3'b100, 32'h22, 32'h0,        4, 1, 32'h0,        0, 32'hFFFFBEEF);
        vt[4]  = mk(1, 0, 1, 3'b000, 32'h30, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1, 32'h30);
        vt[5]  = mk(1, 1, 0, 3'b000, 32'h30, 32'h0,        5, 1, 32'h0,        0, 32'hDEADBEEF);
        vt[6]  = mk(1, 1, 0, 3'b110, 32'h33, 32'h0,        6, 1, 32'h0,        0, 32'hFFFFFFDE);
        vt[7]  = mk(1, 1, 0, 3'b101, 32'h32, 32'h0,        7, 1, 32'h0,        0, 32'h0000DEAD);
        vt[8]  = mk(1, 0, 0, 3'b000, 32'h12345679, 32'h0,  8, 1, 32'h0,        0, 32'h12345679);
        vt[9]  = mk(0, 0, 1, 3'b000, 32'h50, 32'h55555555, 0, 0, 32'h55555555, 0, 32'h0);
        vt[10] = mk(1, 0, 1, 3'b010, 32'h13, 32'h000000AA, 0, 0, 32'hAAAAAAAA, 1, 32'h13);
        vt[11] = mk(1, 1, 0, 3'b110, 32'h13, 32'h0,        9, 1, 32'h0,        0, 32'hFFFFFFAA);
        vt[12] = mk(1, 1, 0, 3'b000, 32'h10, 32'h0,       10, 1, 32'h0,        0, 32'hAA00EF00);
        vt[13] = mk(1, 1, 0, 3'b101, 32'h10, 32'h0,       11, 1, 32'h0,        0, 32'h0000EF00);

        rst = 1'b1; mem_init = 1'b1; stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_dm_we", 32'(dm_we), 32'h0);
        chk("rst_dm_mem_op", 32'(dm_mem_op), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_exc_misalign", 32'(exc_misalign), 32'h0);
        chk("rst_exc_addr", exc_addr, 32'h0);
        rst = 1'b0; mem_init = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vt[i].v, vt[i].rd_en, vt[i].wr_en, vt[i].op, vt[i].addr, vt[i].sdata, vt[i].rd, vt[i].rw);
            if (vt[i].v) push(vt[i].rd, vt[i].rw, vt[i].exp_wb, 1'b1);
            tick();
            chk($sformatf("v%0d_dm_we", i), 32'(dm_we), 32'(vt[i].exp_we));
            chk($sformatf("v%0d_dm_wdata", i), dm_wdata, vt[i].exp_wdata);
            chk($sformatf("v%0d_dm_addr", i), dm_addr, vt[i].addr);
            chk($sformatf("v%0d_dm_mem_op", i), 32'(dm_mem_op), 32'(vt[i].op));
        end
        bubble(2);
        chk("aligned_no_fault", 32'(exc_misalign), 32'h0);

        // Misaligned LW, then an ALU op and a store that enter while faulted.
        @(negedge clk);
        drive(1, 1, 0, 3'b000, 32'h06, 32'h0, 5'd12, 1);
        push(5'd12, 1'b0, 32'h0, 1'b0);
        tick();
        chk("mis_dm_we", 32'(dm_we), 32'h0);
        chk("mis_exc_pre", 32'(exc_misalign), 32'h0);
        @(negedge clk);
        drive(1, 0, 0, 3'b000, 32'h77, 32'h0, 5'd13, 1);
        push(5'd13, 1'b0, 32'h77, 1'b1);
        tick();
        chk("mis_exc_set", 32'(exc_misalign), 32'h1);
        chk("mis_exc_addr", exc_addr, 32'h06);
        @(negedge clk);
        drive(1, 0, 1, 3'b000, 32'h4C, 32'h11111111, 5'd0, 0);
        push(5'd0, 1'b0, 32'h4C, 1'b1);
        tick();
        chk("fault_dm_we", 32'(dm_we), 32'h0);
        chk("fault_exc_hold", 32'(exc_misalign), 32'h1);
        chk("fault_exc_addr_hold", exc_addr, 32'h06);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        exc_ack = 1'b1;
        tick();
        chk("ack_exc_clear", 32'(exc_misalign), 32'h0);
        @(negedge clk);
        exc_ack = 1'b0;
        drive(1, 1, 0, 3'b000, 32'h4C, 32'h0, 5'd14, 1);
        push(5'd14, 1'b1, 32'h0, 1'b1);
        tick();
        bubble(2);

        // Store held in MEM for three stall cycles.
        @(negedge clk);
        drive(1, 0, 1, 3'b000, 32'h40, 32'h13579BDF, 5'd0, 0);
        push(5'd0, 1'b0, 32'h40, 1'b1);
        tick();
        chk("stall_pre_we", 32'(dm_we), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall = 1'b1;
            drive(1, 0, 0, 3'b000, 32'h99, 32'h0, 5'd20, 1);
            tick();
            chk($sformatf("stall%0d_addr", k), dm_addr, 32'h40);
            chk($sformatf("stall%0d_wdata", k), dm_wdata, 32'h13579BDF);
            chk($sformatf("stall%0d_we", k), 32'(dm_we), 32'h1);
            chk($sformatf("stall%0d_wb_valid", k), 32'(wb_valid), 32'h0);
        end
        @(negedge clk);
        stall = 1'b0;
        drive(1, 1, 0, 3'b000, 32'h40, 32'h0, 5'd15, 1);
        push(5'd15, 1'b1, 32'h13579BDF, 1'b1);
        tick();
        bubble(2);
        chk("stall_mem_word", mem_word(8'h40), 32'h13579BDF);

        // Stall and flush together kill the store in MEM.
        @(negedge clk);
        drive(1, 0, 1, 3'b000, 32'h44, 32'hCAFEF00D, 5'd0, 0);
        tick();
        chk("sf_pre_we", 32'(dm_we), 32'h1);
        @(negedge clk);
        stall = 1'b1; flush = 1'b1;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        #1;
        chk("sf_dm_we", 32'(dm_we), 32'h0);
        tick();
        chk("sf_wb_valid", 32'(wb_valid), 32'h0);
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        tick();
        chk("sf_mem_word", mem_word(8'h44), 32'h0);
        @(negedge clk);
        drive(1, 1, 0, 3'b000, 32'h44, 32'h0, 5'd16, 1);
        push(5'd16, 1'b1, 32'h0, 1'b1);
        tick();
        bubble(2);

        // Asynchronous reset between edges while a store sits in MEM.
        @(negedge clk);
        drive(1, 0, 1, 3'b000, 32'h48, 32'h5A5A5A5A, 5'd0, 0);
        tick();
        chk("ar_pre_we", 32'(dm_we), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_dm_we", 32'(dm_we), 32'h0);
        chk("ar_dm_addr", dm_addr, 32'h0);
        chk("ar_dm_wdata", dm_wdata, 32'h0);
        chk("ar_wb_valid", 32'(wb_valid), 32'h0);
        chk("ar_wb_reg_write", 32'(wb_reg_write), 32'h0);
        chk("ar_wb_rd", 32'(wb_rd), 32'h0);
        chk("ar_wb_data", wb_data, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("ar_mem_word", mem_word(8'h48), 32'h0);
        drive(1, 0, 1, 3'b000, 32'h48, 32'h0F0F0F0F, 5'd0, 0);
        push(5'd0, 1'b0, 32'h48, 1'b1);
        tick();
        chk("ar_run_we", 32'(dm_we), 32'h1);
        @(negedge clk);
        drive(1, 1, 0, 3'b000, 32'h48, 32'h0, 5'd17, 1);
        push(5'd17, 1'b1, 32'h0F0F0F0F, 1'b1);
        tick();
        bubble(3);

        chk("sb_drain", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
